// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: control-bundle bit positions and FSM states.
package mem_stage_pkg;

  localparam int M_BRANCH    = 2;
  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_memwb.sv
// MEM/WB pipeline register: loads the stage results, or a zeroed bubble.
module memwb_reg (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [1:0]  wb_next,
  input  logic [31:0] read_data_next,
  input  logic [31:0] alu_result_next,
  input  logic [4:0]  write_reg_next,
  output logic [1:0]  wb,
  output logic [31:0] read_data,
  output logic [31:0] alu_result,
  output logic [4:0]  write_reg
);

  always_ff @(posedge clock) begin
    if (!reset || bubble) begin
      wb         <= 2'b00;
      read_data  <= 32'd0;
      alu_result <= 32'd0;
      write_reg  <= 5'd0;
    end else if (load) begin
      wb         <= wb_next;
      read_data  <= read_data_next;
      alu_result <= alu_result_next;
      write_reg  <= write_reg_next;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, req/ack data-memory access with stall,
// misalign and timeout detection, feeding the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  EXMEM_wb,
  input  logic [2:0]  EXMEM_m,
  input  logic [31:0] EXMEM_branchTarget,
  input  logic        EXMEM_zero,
  input  logic [31:0] EXMEM_aluResult,
  input  logic [31:0] EXMEM_memWriteData,
  input  logic [4:0]  EXMEM_writeReg,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        PCSrc,
  output logic [31:0] branchTarget,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [1:0]  MEMWB_wb,
  output logic [31:0] MEMWB_readData,
  output logic [31:0] MEMWB_aluResult,
  output logic [4:0]  MEMWB_writeReg,
  output logic        mem_error
);

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             error_reg;

  logic        access;
  logic        in_wait;
  logic        misaligned;
  logic        timed_out;
  logic        complete;
  logic        abort;
  logic        bubble;
  logic [1:0]  wb_next;
  logic [31:0] read_data_next;

  assign access  = EXMEM_m[M_READ] | EXMEM_m[M_WRITE];
  assign in_wait = (state_reg == WAIT);

  // EX/MEM is frozen while waiting, so alignment only needs judging on entry.
  assign misaligned = access & (EXMEM_aluResult[1:0] != 2'b00) & ~in_wait;
  assign dmem_req   = reset & (in_wait | (access & ~misaligned));
  assign timed_out  = in_wait & (count_reg == CNT_W'(TIMEOUT));

  assign complete = dmem_req & dmem_ack;
  assign abort    = dmem_req & ~dmem_ack & timed_out;
  assign stall    = dmem_req & ~dmem_ack & ~timed_out;
  assign bubble   = stall | misaligned | abort;

  assign dmem_we      = dmem_req & EXMEM_m[M_WRITE] & ~EXMEM_m[M_READ];
  assign dmem_addr    = {EXMEM_aluResult[31:2], 2'b00};
  assign dmem_wdata   = EXMEM_memWriteData;
  assign PCSrc        = EXMEM_m[M_BRANCH] & EXMEM_zero;
  assign branchTarget = EXMEM_branchTarget;
  assign mem_error    = error_reg;

  assign wb_next        = {EXMEM_wb[WB_REGWRITE], EXMEM_wb[WB_MEMTOREG]};
  assign read_data_next = (complete & EXMEM_m[M_READ]) ? dmem_rdata : 32'd0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      error_reg <= misaligned | abort;
      case (state_reg)
        IDLE: begin
          if (stall) begin
            state_reg <= WAIT;
            count_reg <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (stall) begin
            count_reg <= count_reg + CNT_W'(1);
          end else begin
            state_reg <= IDLE;
            count_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
        end
      endcase
    end
  end

  memwb_reg u_memwb (
    .clock           (clock),
    .reset           (reset),
    .load            (~bubble),
    .bubble          (bubble),
    .wb_next         (wb_next),
    .read_data_next  (read_data_next),
    .alu_result_next (EXMEM_aluResult),
    .write_reg_next  (EXMEM_writeReg),
    .wb              (MEMWB_wb),
    .read_data       (MEMWB_readData),
    .alu_result      (MEMWB_aluResult),
    .write_reg       (MEMWB_writeReg)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: an instruction-level model predicts every
// cycle's outputs from the access latency chosen for each instruction.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  EXMEM_wb;
  logic [2:0]  EXMEM_m;
  logic [31:0] EXMEM_branchTarget;
  logic        EXMEM_zero;
  logic [31:0] EXMEM_aluResult;
  logic [31:0] EXMEM_memWriteData;
  logic [4:0]  EXMEM_writeReg;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        PCSrc;
  logic [31:0] branchTarget;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [1:0]  MEMWB_wb;
  logic [31:0] MEMWB_readData;
  logic [31:0] MEMWB_aluResult;
  logic [4:0]  MEMWB_writeReg;
  logic        mem_error;

  always #5 clock = ~clock;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .EXMEM_wb(EXMEM_wb), .EXMEM_m(EXMEM_m), .EXMEM_branchTarget(EXMEM_branchTarget),
    .EXMEM_zero(EXMEM_zero), .EXMEM_aluResult(EXMEM_aluResult),
    .EXMEM_memWriteData(EXMEM_memWriteData), .EXMEM_writeReg(EXMEM_writeReg),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .PCSrc(PCSrc), .branchTarget(branchTarget), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .MEMWB_wb(MEMWB_wb), .MEMWB_readData(MEMWB_readData), .MEMWB_aluResult(MEMWB_aluResult),
    .MEMWB_writeReg(MEMWB_writeReg), .mem_error(mem_error)
  );

  int total = 0;
  int bad   = 0;
  int req_cnt = 0, stall_cnt = 0, we_cnt = 0;
  logic check_en = 1'b0;

  // Expected outputs for the current cycle
  logic        exp_pcsrc, exp_req, exp_we, exp_stall, exp_err, exp_data_chk;
  logic [31:0] exp_target, exp_addr, exp_wdata, exp_rd, exp_alu;
  logic [1:0]  exp_wb;
  logic [4:0]  exp_wr;
  // Outcome decided this cycle, visible in MEMWB/mem_error next cycle
  logic        nxt_err, nxt_data_chk;
  logic [31:0] nxt_rd, nxt_alu;
  logic [1:0]  nxt_wb;
  logic [4:0]  nxt_wr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    if (check_en) begin
      chk("PCSrc", 32'(PCSrc), 32'(exp_pcsrc));
      chk("branchTarget", branchTarget, exp_target);
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      chk("dmem_we", 32'(dmem_we), 32'(exp_we));
      chk("stall", 32'(stall), 32'(exp_stall));
      if (exp_req) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      chk("MEMWB_wb", 32'(MEMWB_wb), 32'(exp_wb));
      chk("mem_error", 32'(mem_error), 32'(exp_err));
      if (exp_data_chk) begin
        chk("MEMWB_readData", MEMWB_readData, exp_rd);
        chk("MEMWB_aluResult", MEMWB_aluResult, exp_alu);
        chk("MEMWB_writeReg", 32'(MEMWB_writeReg), 32'(exp_wr));
      end
      if (dmem_req) req_cnt++;
      if (stall) stall_cnt++;
      if (dmem_we) we_cnt++;
    end
  end

  task automatic set_bubble(input logic err, input logic data_chk);
    nxt_wb = 2'b00; nxt_rd = 32'd0; nxt_alu = 32'd0; nxt_wr = 5'd0;
    nxt_err = err; nxt_data_chk = data_chk;
  endtask

  // Hold one instruction in EX/MEM until the stage releases it. lat = request
  // cycle in which the memory acks (0 = never); rst_at = cycle index to reset.
  task automatic run_instr(input logic [1:0] wb, input logic [2:0] m, input logic z,
                           input logic [31:0] tgt, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input logic [4:0] wr, input int lat, input int rst_at);
    bit acc, mis, last, ack_now, done;
    int k;
    acc  = m[1] | m[0];
    mis  = acc && (alu[1:0] != 2'b00);
    k    = 0;
    done = 0;
    while (!done) begin
      @(posedge clock); #1;
      exp_wb = nxt_wb; exp_rd = nxt_rd; exp_alu = nxt_alu; exp_wr = nxt_wr;
      exp_err = nxt_err; exp_data_chk = nxt_data_chk;
      reset = (k == rst_at) ? 1'b0 : 1'b1;
      EXMEM_wb = wb; EXMEM_m = m; EXMEM_zero = z; EXMEM_branchTarget = tgt;
      EXMEM_aluResult = alu; EXMEM_memWriteData = wd; EXMEM_writeReg = wr;
      dmem_rdata = rd;
      exp_pcsrc = m[2] & z; exp_target = tgt;
      exp_addr = {alu[31:2], 2'b00}; exp_wdata = wd;
      if (k == rst_at) begin
        dmem_ack = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0;
        set_bubble(1'b0, 1'b1);
        done = 1;
      end else if (!acc || mis) begin
        dmem_ack = 1'($urandom_range(0, 1));
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0;
        if (mis) set_bubble(1'b1, 1'b1);
        else begin
          nxt_wb = wb; nxt_rd = 32'd0; nxt_alu = alu; nxt_wr = wr;
          nxt_err = 1'b0; nxt_data_chk = 1'b1;
        end
        done = 1;
      end else begin
        ack_now  = (lat != 0) && (k == lat - 1);
        dmem_ack = ack_now;
        last     = ack_now || (k == TIMEOUT);
        exp_req = 1'b1; exp_we = m[0] & ~m[1]; exp_stall = !last;
        if (!last) set_bubble(1'b0, 1'b0);
        else if (ack_now) begin
          nxt_wb = wb; nxt_rd = m[1] ? rd : 32'd0; nxt_alu = alu; nxt_wr = wr;
          nxt_err = 1'b0; nxt_data_chk = 1'b1;
        end else set_bubble(1'b1, 1'b0);
        done = last;
      end
      check_en = 1'b1;
      k++;
    end
  endtask

  // A following no-op makes the previous instruction's results visible.
  task automatic nop_settle();
    run_instr(2'b00, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1, -1);
    @(negedge clock); #1;
  endtask

  task automatic zero_counts();
    req_cnt = 0; stall_cnt = 0; we_cnt = 0;
  endtask

  initial begin
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] alu;
    int          sel, r, lat;

    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    EXMEM_wb = 2'b00; EXMEM_m = 3'b000; EXMEM_zero = 1'b0; EXMEM_branchTarget = 32'd0;
    EXMEM_aluResult = 32'd0; EXMEM_memWriteData = 32'd0; EXMEM_writeReg = 5'd0;
    set_bubble(1'b0, 1'b1);
    repeat (2) @(posedge clock);

    // Aligned load held in reset: req and stall must stay low
    run_instr(2'b11, 3'b010, 1'b0, 32'd0, 32'h200, 32'd0, 32'h55, 5'd3, 0, 0);

    // Zero-wait load
    zero_counts();
    run_instr(2'b11, 3'b010, 1'b0, 32'd0, 32'h100, 32'd0, 32'hDEADBEEF, 5'd8, 1, -1);
    nop_settle();
    chk("lw0_stall_cycles", 32'(stall_cnt), 32'd0);
    chk("lw0_readData", MEMWB_readData, 32'hDEADBEEF);
    chk("lw0_wb", 32'(MEMWB_wb), 32'd3);

    // Store acked on its third request cycle
    zero_counts();
    run_instr(2'b00, 3'b001, 1'b0, 32'd0, 32'h40, 32'h12345678, 32'hAAAA5555, 5'd0, 3, -1);
    nop_settle();
    chk("sw3_we_cycles", 32'(we_cnt), 32'd3);
    chk("sw3_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("sw3_readData", MEMWB_readData, 32'd0);

    // Load that never completes
    zero_counts();
    run_instr(2'b11, 3'b010, 1'b0, 32'd0, 32'h80, 32'd0, 32'h1, 5'd4, 0, -1);
    nop_settle();
    chk("timeout_req_cycles", 32'(req_cnt), 32'd17);
    chk("timeout_mem_error", 32'(mem_error), 32'd1);
    chk("timeout_wb", 32'(MEMWB_wb), 32'd0);

    // Misaligned load
    zero_counts();
    run_instr(2'b11, 3'b010, 1'b0, 32'd0, 32'h102, 32'd0, 32'h2, 5'd5, 1, -1);
    nop_settle();
    chk("misalign_req_cycles", 32'(req_cnt), 32'd0);
    chk("misalign_mem_error", 32'(mem_error), 32'd1);
    chk("misalign_wb", 32'(MEMWB_wb), 32'd0);

    // Branch taken / not taken
    run_instr(2'b00, 3'b100, 1'b1, 32'h400, 32'd0, 32'd0, 32'd0, 5'd0, 1, -1);
    @(negedge clock); #1;
    chk("beq_taken_PCSrc", 32'(PCSrc), 32'd1);
    chk("beq_target", branchTarget, 32'h400);
    run_instr(2'b00, 3'b100, 1'b0, 32'h400, 32'd0, 32'd0, 32'd0, 5'd0, 1, -1);
    @(negedge clock); #1;
    chk("beq_not_taken_PCSrc", 32'(PCSrc), 32'd0);

    // Reset in the second WAIT cycle
    run_instr(2'b11, 3'b010, 1'b0, 32'd0, 32'h300, 32'd0, 32'h7, 5'd6, 0, 2);
    nop_settle();
    chk("rst_wait_wb", 32'(MEMWB_wb), 32'd0);
    chk("rst_wait_mem_error", 32'(mem_error), 32'd0);
    chk("rst_wait_req", 32'(dmem_req), 32'd0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       begin m = 3'b010; wb = 2'b11; end
        1:       begin m = 3'b001; wb = 2'b00; end
        2:       begin m = 3'b011; wb = 2'b11; end
        3:       begin m = 3'b100; wb = 2'b00; end
        4:       begin m = 3'b000; wb = 2'b10; end
        default: begin m = 3'($urandom); wb = 2'($urandom); end
      endcase
      alu = $urandom;
      if ($urandom_range(0, 99) < 80) alu[1:0] = 2'b00;
      r = $urandom_range(0, 99);
      if (r < 8)       lat = 0;
      else if (r < 14) lat = TIMEOUT + 1;
      else if (r < 20) lat = TIMEOUT;
      else             lat = $urandom_range(1, 4);
      run_instr(wb, m, 1'($urandom), $urandom, alu, $urandom, $urandom, 5'($urandom), lat, -1);
    end
    nop_settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register and consuming its full output bundle. It resolves branches (PCSrc), drives a variable-latency data-memory port through a req/ack handshake, stalls the front of the pipeline while an access is outstanding, and registers results into the MEM/WB pipeline register. It also detects misaligned and timed-out accesses.

## Interface
- TIMEOUT, 16: max cycles in WAIT before an access is aborted
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low
- EXMEM_wb  input  2  [1]=RegWrite, [0]=MemtoReg
- EXMEM_m  input  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- EXMEM_branchTarget  input  32  branch target address
- EXMEM_zero  input  1  ALU zero flag
- EXMEM_aluResult  input  32  ALU result / memory byte address
- EXMEM_memWriteData  input  32  store data
- EXMEM_writeReg  input  5  destination register
- dmem_rdata  input  32  load data, valid when dmem_ack=1
- dmem_ack  input  1  access complete
- PCSrc  output  1  take-branch select to IF
- branchTarget  output  32  EXMEM_branchTarget passthrough
- stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM
- dmem_req, dmem_we  output  1 each  request / write enable
- dmem_addr, dmem_wdata  output  32 each  word address (byte address, [1:0]=0), store data
- MEMWB_wb  output  2  registered control
- MEMWB_readData, MEMWB_aluResult  output  32 each  registered load data / ALU result
- MEMWB_writeReg  output  5  registered destination
- mem_error  output  1  one-cycle registered pulse on misalign or timeout

## Operation
- access = EXMEM_m[1] | EXMEM_m[0]; both set is treated as a load (MemRead wins, dmem_we=0).
- PCSrc = EXMEM_m[2] & EXMEM_zero, combinational, independent of state.
- misaligned = access & (EXMEM_aluResult[1:0] != 0): no dmem_req; MEMWB loads a bubble (wb=0, data fields 0); mem_error=1 next cycle; no stall.
- FSM states IDLE, WAIT.
  - IDLE, aligned access: dmem_req=1, dmem_we=EXMEM_m[0]&~EXMEM_m[1], dmem_addr=aluResult, dmem_wdata=memWriteData (combinational). ack same cycle -> complete, stay IDLE. No ack -> stall=1, go WAIT, counter=1.
  - WAIT: request signals held from (stable) EXMEM; stall=1 unless ack. ack -> complete, go IDLE. counter==TIMEOUT without ack -> abort: req drops, stall=0, MEMWB bubble, mem_error next cycle, go IDLE. Otherwise counter+1.
- Complete: MEMWB_* <= EXMEM_* fields, MEMWB_readData <= dmem_rdata for loads, 0 for stores.
- Non-access instruction: MEMWB loads EXMEM fields, readData=0, no stall.
- Every cycle with stall=1: MEMWB loads a bubble (wb=0).
- ack outside a request is ignored.

## Timing
- Reset (reset=0 at posedge): state=IDLE, counter=0, all MEMWB_* =0, mem_error=0; stall, dmem_req, dmem_we, PCSrc follow combinational rules (req/stall forced 0 while reset=0).
- Reset during WAIT aborts the access with no mem_error.
- Zero-wait load: 1 cycle in MEM, no stall. N-cycle ack (ack in Nth cycle of request): stall high N-1 cycles.
- Timeout: request asserted TIMEOUT+1 cycles total (IDLE cycle + TIMEOUT WAIT cycles); stall low on the last.
- mem_error and MEMWB outputs appear the cycle after the decision edge.

## Structure
- Shared package: m/wb bit-index constants (M_BRANCH=2, M_READ=1, M_WRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0), state enum {IDLE, WAIT}.
- One sub-module natural: memwb_reg (MEM/WB register with load/bubble inputs); FSM, counter and port drive live in mem_stage.

## Test plan
- lw, aluResult=0x100, ack same cycle, rdata=0xDEADBEEF -> stall never 1; next cycle MEMWB_readData=0xDEADBEEF, MEMWB_wb=2'b11.
- sw, aluResult=0x40, data=0x12345678, ack on 3rd request cycle -> dmem_we=1 for 3 cycles, stall high 2 cycles, MEMWB_readData=0.
- lw, no ack, TIMEOUT=16 -> req high 17 cycles, mem_error pulse 1 cycle, MEMWB_wb=0.
- lw, aluResult=0x102 -> dmem_req=0, mem_error=1 next cycle, MEMWB_wb=0.
- beq with m=3'b100, zero=1, target=0x400 -> PCSrc=1, branchTarget=0x400; zero=0 -> PCSrc=0.
- reset=0 asserted in WAIT cycle 2 -> next cycle state IDLE, all MEMWB_*=0, mem_error=0, req=0.
